// File: rtl/spi_slave_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_rx_if
// Description : Pin-side SPI signals and consumer-side FIFO read port of the
//               SPI slave receiver, bundled for connection to spi_slave_rx.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_slave_rx_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              sck;
    logic              mosi;
    logic              ss_n;
    logic              rd_en;
    logic              clr_err;
    logic [DATA_W-1:0] rd_data;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              word_strb;
    logic              overflow;
    logic              frame_err;

    // Driving side: the SPI master pins plus the local consumer controls.
    modport master (
        output sck, mosi, ss_n, rd_en, clr_err,
        input  rd_data, empty, full, count, word_strb, overflow, frame_err
    );

    // Receiver side.
    modport slave (
        input  sck, mosi, ss_n, rd_en, clr_err,
        output rd_data, empty, full, count, word_strb, overflow, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/spi_slave_rx.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_rx
// Description : SPI mode-0 slave receiver. Oversamples sck/mosi/ss_n in the
//               clk domain, deserialises MSB-first words and queues them in a
//               first-word-fall-through FIFO with sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_rx #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    spi_slave_rx_if.slave   bus
);
    localparam int                  c_CNT_W    = $clog2(DATA_W);
    localparam logic [c_CNT_W-1:0]  c_BIT_LAST = c_CNT_W'(DATA_W - 1);
    localparam logic [c_CNT_W-1:0]  c_BIT_ONE  = c_CNT_W'(1);
    localparam logic [ADDR_W-1:0]   c_PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]     c_CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]     c_CNT_FULL = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_WAIT_IDLE = 2'd0,
        S_IDLE      = 2'd1,
        S_SHIFT     = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0]   r_shreg;
    logic                r_word_strb;
    logic                r_frame_err;
    logic                r_overflow;

    logic r_sck_s1, r_sck_s2, r_sck_s3;
    logic r_mosi_s1, r_mosi_s2;
    logic r_ss_s1, r_ss_s2;
    logic w_sck_rise;

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_wptr, r_rptr;
    logic [ADDR_W:0]     r_count;
    logic [ADDR_W:0]     w_count_nxt;
    logic                r_empty, r_full;
    logic                w_push, w_pop;

    // Two-flop synchronisers; ss_n resets low so a frame already running at
    // reset keeps the FSM parked in WAIT_IDLE until the master deselects.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sck_s1  <= 1'b0;
            r_sck_s2  <= 1'b0;
            r_sck_s3  <= 1'b0;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
            r_ss_s1   <= 1'b0;
            r_ss_s2   <= 1'b0;
        end else begin
            r_sck_s1  <= bus.sck;
            r_sck_s2  <= r_sck_s1;
            r_sck_s3  <= r_sck_s2;
            r_mosi_s1 <= bus.mosi;
            r_mosi_s2 <= r_mosi_s1;
            r_ss_s1   <= bus.ss_n;
            r_ss_s2   <= r_ss_s1;
        end
    end

    assign w_sck_rise = r_sck_s2 & ~r_sck_s3;

    // Frame FSM: shifts bits on sck rise, strobes completed words, flags
    // frames that end mid-word. A set of frame_err overrides clr_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_WAIT_IDLE;
            r_bit_cnt   <= '0;
            r_shreg     <= '0;
            r_word_strb <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_word_strb <= 1'b0;
            if (bus.clr_err) begin
                r_frame_err <= 1'b0;
            end
            case (r_state)
                S_WAIT_IDLE: begin
                    if (r_ss_s2) begin
                        r_state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (!r_ss_s2) begin
                        r_state   <= S_SHIFT;
                        r_bit_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    if (r_ss_s2) begin
                        r_state <= S_IDLE;
                        if (r_bit_cnt != '0) begin
                            r_frame_err <= 1'b1;
                        end
                    end else if (w_sck_rise) begin
                        r_shreg <= {r_shreg[DATA_W-2:0], r_mosi_s2};
                        if (r_bit_cnt == c_BIT_LAST) begin
                            r_bit_cnt   <= '0;
                            r_word_strb <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + c_BIT_ONE;
                        end
                    end
                end
                default: r_state <= S_WAIT_IDLE;
            endcase
        end
    end

    // A completed word is pushed the cycle after word_strb; a same-cycle pop
    // makes room even when full.
    assign w_pop  = bus.rd_en & ~r_empty;
    assign w_push = r_word_strb & (~r_full | bus.rd_en);

    // Next occupancy, used to register full/empty consistently with count.
    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + c_CNT_ONE;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - c_CNT_ONE;
        end
    end

    // FIFO pointers, occupancy and overflow flag (set wins over clr_err).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == c_CNT_FULL);
            if (r_word_strb && r_full && !bus.rd_en) begin
                r_overflow <= 1'b1;
            end else if (bus.clr_err) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= r_shreg;
        end
    end

    assign bus.rd_data   = r_empty ? '0 : r_mem[r_rptr];
    assign bus.empty     = r_empty;
    assign bus.full      = r_full;
    assign bus.count     = r_count;
    assign bus.word_strb = r_word_strb;
    assign bus.overflow  = r_overflow;
    assign bus.frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_rx
// Description : Directed self-checking bench for spi_slave_rx.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_rx;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic clk;
    logic rst;
    int   total;
    int   fails;
    int   strb_cnt;

    spi_slave_rx_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    spi_slave_rx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Counts word_strb pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (bus.word_strb) strb_cnt = strb_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input int h);
        bus.mosi = b;
        cyc(h);
        bus.sck = 1'b1;
        cyc(h);
        bus.sck = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] w, input int nbits, input int h);
        for (int i = 31; i > 31 - nbits; i--) send_bit(w[i], h);
    endtask

    task automatic send_word(input logic [31:0] w, input int h);
        send_bits(w, 32, h);
    endtask

    // Sends a word but stops right when word_strb is seen (sck left high).
    task automatic send_word_to_strb(input logic [31:0] w, input int h, output bit got);
        send_bits(w, 31, h);
        bus.mosi = w[0];
        cyc(h);
        bus.sck = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (bus.word_strb) got = 1'b1;
        end
    endtask

    task automatic frame_begin();
        bus.ss_n = 1'b0;
        cyc(4);
    endtask

    task automatic frame_end();
        cyc(4);
        bus.ss_n = 1'b1;
        cyc(5);
    endtask

    task automatic pop();
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    logic [31:0] exp_q [16];
    logic [31:0] spd   [8];
    bit          got;

    initial begin
        total = 0; fails = 0; strb_cnt = 0;
        bus.sck = 1'b0; bus.mosi = 1'b0; bus.ss_n = 1'b1;
        bus.rd_en = 1'b0; bus.clr_err = 1'b0;
        rst = 1'b1;
        cyc(4);
        chk("rst_empty", bus.empty, 1);
        chk("rst_full", bus.full, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_strb", bus.word_strb, 0);
        chk("rst_ovf", bus.overflow, 0);
        chk("rst_ferr", bus.frame_err, 0);
        rst = 1'b0;
        cyc(5);

        // Single word with latency of the FIFO write after word_strb.
        frame_begin();
        send_word_to_strb(32'hA5C3_0F01, 4, got);
        chk("single_strb_seen", got, 1);
        chk("single_count_at_strb", bus.count, 0);
        @(negedge clk);
        chk("single_count_after", bus.count, 1);
        chk("single_empty_after", bus.empty, 0);
        chk("single_rd_data", bus.rd_data, 32'hA5C3_0F01);
        cyc(3);
        bus.sck = 1'b0;
        frame_end();
        chk("single_strb_cnt", strb_cnt, 1);
        pop();
        chk("single_pop_empty", bus.empty, 1);
        chk("single_pop_rd_data", bus.rd_data, 0);

        // Back-to-back words 0..19: 16 stored, 4 dropped.
        strb_cnt = 0;
        frame_begin();
        for (int i = 0; i < 20; i++) send_word(32'(i), 4);
        frame_end();
        chk("b2b_strb_cnt", strb_cnt, 20);
        chk("b2b_full", bus.full, 1);
        chk("b2b_count", bus.count, 16);
        chk("b2b_ovf", bus.overflow, 1);
        chk("b2b_ferr", bus.frame_err, 0);
        for (int i = 0; i < 16; i++) begin
            chk("b2b_drain_data", bus.rd_data, 32'(i));
            chk("b2b_drain_count", bus.count, 64'(16 - i));
            pop();
        end
        chk("b2b_empty", bus.empty, 1);
        chk("b2b_count_end", bus.count, 0);
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        chk("b2b_ovf_clr", bus.overflow, 0);

        // Fill, then complete 0xDEADBEEF in the same cycle as a pop.
        frame_begin();
        for (int i = 0; i < 16; i++) send_word(32'h100 + 32'(i), 4);
        chk("pp_full_before", bus.full, 1);
        send_word_to_strb(32'hDEAD_BEEF, 4, got);
        chk("pp_strb_seen", got, 1);
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
        chk("pp_count", bus.count, 16);
        chk("pp_ovf", bus.overflow, 0);
        cyc(3);
        bus.sck = 1'b0;
        frame_end();
        for (int i = 0; i < 15; i++) exp_q[i] = 32'h101 + 32'(i);
        exp_q[15] = 32'hDEAD_BEEF;
        for (int i = 0; i < 16; i++) begin
            chk("pp_drain_data", bus.rd_data, exp_q[i]);
            pop();
        end
        chk("pp_empty", bus.empty, 1);

        // Frame error after 13 bits, then a good word, then clear.
        frame_begin();
        send_bits(32'hFFFF_FFFF, 13, 4);
        frame_end();
        chk("ferr_set", bus.frame_err, 1);
        chk("ferr_count", bus.count, 0);
        frame_begin();
        send_word(32'h0000_0042, 4);
        frame_end();
        chk("ferr_next_data", bus.rd_data, 32'h0000_0042);
        chk("ferr_next_count", bus.count, 1);
        chk("ferr_still_set", bus.frame_err, 1);
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        chk("ferr_clr", bus.frame_err, 0);

        // Reset mid-frame with one word still queued.
        strb_cnt = 0;
        frame_begin();
        send_bits(32'hFFFF_FFFF, 20, 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_count", bus.count, 0);
        chk("rstmid_empty", bus.empty, 1);
        send_bits(32'hFFFF_FFFF, 12, 4);
        cyc(4);
        chk("rstmid_no_strb", strb_cnt, 0);
        bus.ss_n = 1'b1;
        cyc(5);
        frame_begin();
        send_word(32'h1234_5678, 4);
        frame_end();
        chk("rstmid_strb", strb_cnt, 1);
        chk("rstmid_data", bus.rd_data, 32'h1234_5678);
        chk("rstmid_count_new", bus.count, 1);
        pop();

        // Fastest legal sck: 3-cycle phases, 8 words.
        spd[0] = 32'h0000_0001; spd[1] = 32'hFFFF_FFFF;
        spd[2] = 32'h8000_0000; spd[3] = 32'h7FFF_FFFF;
        spd[4] = 32'hAAAA_5555; spd[5] = 32'h1357_9BDF;
        spd[6] = 32'hCAFE_F00D; spd[7] = 32'h0F0F_F0F0;
        frame_begin();
        for (int i = 0; i < 8; i++) send_word(spd[i], 3);
        frame_end();
        chk("spd_count", bus.count, 8);
        chk("spd_ovf", bus.overflow, 0);
        chk("spd_ferr", bus.frame_err, 0);
        for (int i = 0; i < 8; i++) begin
            chk("spd_data", bus.rd_data, spd[i]);
            pop();
        end
        chk("spd_empty", bus.empty, 1);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/spi_slave_rx.md
# spi_slave_rx

SPI slave receiver for the other end of the board's SPI link. It samples `sck`/`mosi`/`ss_n` driven by an external SPI master in the fabric clock domain and deserialises MSB-first words. Completed words are pushed into an internal first-word-fall-through FIFO that the local consumer drains. It sits between the GPIO pins and consumer logic such as SSD display or checksum blocks, and lets a bench or second board loop back the transmitter's stream.

## Interface
Parameters:
- `DATA_W`, 32: word width in bits; one word = `DATA_W` sck rising edges.
- `DEPTH`, 16: FIFO depth in words; power of two, ≥ 2.
- `ADDR_W`, 4: log2(`DEPTH`).

Ports:
- `clk`  in  1  fabric clock (50 MHz); all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sck`  in  1  SPI clock, asynchronous to `clk`, idle low.
- `mosi`  in  1  SPI data from the master, asynchronous.
- `ss_n`  in  1  SPI slave select, active low, asynchronous.
- `rd_en`  in  1  pop request; ignored while `empty`=1.
- `clr_err`  in  1  clears the `overflow` and `frame_err` flags.
- `rd_data`  out  `DATA_W`  FIFO head word; 0 while `empty`=1.
- `empty`  out  1  FIFO empty.
- `full`  out  1  FIFO holds `DEPTH` words.
- `count`  out  `ADDR_W`+1  number of words in the FIFO (0..`DEPTH`).
- `word_strb`  out  1  one-cycle pulse when a word is completed, whether pushed or dropped.
- `overflow`  out  1  sticky; set when a completed word is dropped because the FIFO was full.
- `frame_err`  out  1  sticky; set when `ss_n` rises with a partial word in the shift register.

## Operation
- SPI mode 0 (CPOL=0, CPHA=0): `mosi` is sampled on the rising edge of `sck`, MSB first.
- Synchronisation:
  - `sck`, `mosi` and `ss_n` each pass through a 2-flop synchroniser.
  - A third `sck` flop forms the rising-edge detect: `sck_rise` = s2 & ~s3.
  - The value of `mosi` shifted in is its s2 value in the cycle where `sck_rise` is detected.
- FSM states:
  - WAIT_IDLE (reset state): → IDLE when synchronised `ss_n`=1. No edges are accepted in this state, so a frame already in progress at reset is discarded.
  - IDLE: → SHIFT when synchronised `ss_n`=0. `bit_cnt` is cleared on entry.
  - SHIFT, on `sck_rise`: `shreg` ← {`shreg`[`DATA_W`-2:0], `mosi`}, `bit_cnt` +1.
  - SHIFT, when `bit_cnt` reaches `DATA_W`-1 and another `sck_rise` occurs: the word is complete, `bit_cnt` wraps to 0, `word_strb`=1, and a push is attempted. Back-to-back words in one `ss_n` frame are legal.
  - SHIFT, on synchronised `ss_n` rise: → IDLE. If `bit_cnt`≠0, `frame_err` is set and the partial word is discarded.
- FIFO behaviour:
  - Circular buffer with `ADDR_W`-bit write and read pointers. Both wrap at `DEPTH`.
  - Push when a word completes and (`full`=0 or `rd_en`=1). A pop frees the slot in the same cycle.
  - Pop when `rd_en`=1 and `empty`=0. `rd_data` shows the new head in the following cycle.
  - Simultaneous push and pop: `count` is unchanged and both pointers advance.
  - Push into an empty FIFO: the word appears on `rd_data` with `empty`=0 one cycle after `word_strb`.
  - A word completing while `full`=1 with no pop: the word is dropped, `overflow` is set, and the FIFO contents are unchanged.
- Flags:
  - `clr_err`=1 clears both sticky flags in that cycle.
  - If a set event coincides with `clr_err`, set wins.

## Timing
- Reset values: state WAIT_IDLE, `bit_cnt`=0, `shreg`=0, pointers 0, `count`=0, `empty`=1, `full`=0, `rd_data`=0, `word_strb`=0, `overflow`=0, `frame_err`=0.
- `rst` has priority over every other input. Asserting it mid-frame flushes the FIFO and discards the partial word.
- Latency:
  - A pin-level `sck` rising edge is shifted in 3 `clk` cycles later.
  - `word_strb` pulses in the same cycle as the final shift.
  - FIFO write, and the `count`/`empty` update, take effect 1 cycle after `word_strb`.
- Input requirements:
  - `sck` high and low phases must each be ≥ 3 `clk` periods, giving a maximum sck of about 8 MHz at 50 MHz.
  - `mosi` must be stable ≥ 2 `clk` before and after each `sck` rising edge.
  - `ss_n` must fall ≥ 3 `clk` before the first `sck` rise and rise ≥ 3 `clk` after the last one.
- `full` = (`count`==`DEPTH`); `empty` = (`count`==0). Both are registered and consistent with `count` in the same cycle.

## Test plan
- **Single word:** after reset, a frame with `ss_n` low carrying 0xA5C3_0F01 → one `word_strb` pulse, then `rd_data`=0xA5C3_0F01, `count`=1 and `empty`=0; `rd_en` for 1 cycle → `empty`=1 and `rd_data`=0.
- **Back-to-back:** one frame carrying the incrementing words 0..19 with no `rd_en` → the first 16 words are stored, `full`=1, `overflow`=1 after word 16 and 4 words dropped; draining yields 0..15 in order with `count` counting down to 0.
- **Push and pop together:** FIFO full, word 0xDEAD_BEEF completes in the same cycle as `rd_en` → no overflow, `count` stays 16, and 0xDEAD_BEEF is read last after wrap-around.
- **Frame error:** `ss_n` rises after 13 bits → `frame_err`=1, `count` unchanged; the next full word 0x0000_0042 is received correctly; `clr_err` → `frame_err`=0.
- **Reset mid-frame:** `rst` pulsed after 20 bits with `ss_n` still low, and the frame then continues → no `word_strb` until `ss_n` goes high and a new frame starts; the new word 0x1234_5678 is read intact.
- **Speed limit:** sck with 3-cycle high/low phases, 8 words → all received without error; `overflow` and `frame_err` stay 0.
